// File: rtl/md5_msg_padder.sv
// MD5 front end: packs a byte stream into little-endian 512-bit blocks and
// appends 0x80, zero fill and the 64-bit message bit length.
module md5_msg_padder #(
    parameter int unsigned CNT_W = 61
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_valid_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    input  logic              msg_empty_i,
    output logic [15:0][31:0] M_o,
    output logic              blk_valid_o,
    output logic              blk_last_o,
    input  logic              blk_ready_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_FILL,
        S_PAD80,
        S_LEN,
        S_EMIT
    } state_e;

    state_e             state_q, state_d;
    logic [5:0]         ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [511:0]       blk_q;
    logic               need80_q;
    logic               len_pend_q;
    logic               last_blk_q;
    logic [63:0]        bitlen;

    assign bitlen = 64'({cnt_q, 3'b000});

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL: begin
                if (in_valid_i) begin
                    if (ptr_q == 6'd63)
                        state_d = S_EMIT;
                    else if (in_last_i)
                        state_d = S_PAD80;
                end else if (msg_empty_i && ptr_q == '0 && cnt_q == '0) begin
                    state_d = S_PAD80;
                end
            end
            S_PAD80: state_d = (ptr_q <= 6'd55) ? S_LEN : S_EMIT;
            S_LEN:   state_d = S_EMIT;
            S_EMIT: begin
                if (blk_ready_i) begin
                    if (last_blk_q)
                        state_d = S_FILL;
                    else if (need80_q)
                        state_d = S_PAD80;
                    else if (len_pend_q)
                        state_d = S_LEN;
                    else
                        state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            state_q <= S_FILL;
        else
            state_q <= state_d;
    end

    // Buffer is cleared on every handshake so zero padding never costs a cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr_q      <= '0;
            cnt_q      <= '0;
            blk_q      <= '0;
            need80_q   <= 1'b0;
            len_pend_q <= 1'b0;
            last_blk_q <= 1'b0;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (in_valid_i) begin
                        blk_q[{ptr_q, 3'b000} +: 8] <= in_data_i;
                        cnt_q <= cnt_q + CNT_W'(1);
                        ptr_q <= ptr_q + 6'd1;
                        if (ptr_q == 6'd63 && in_last_i)
                            need80_q <= 1'b1;
                    end
                end
                S_PAD80: begin
                    blk_q[{ptr_q, 3'b000} +: 8] <= 8'h80;
                    if (ptr_q >= 6'd56)
                        len_pend_q <= 1'b1;
                end
                S_LEN: begin
                    blk_q[511:448] <= bitlen;
                    last_blk_q     <= 1'b1;
                end
                S_EMIT: begin
                    if (blk_ready_i) begin
                        blk_q <= '0;
                        ptr_q <= '0;
                        if (last_blk_q) begin
                            cnt_q      <= '0;
                            last_blk_q <= 1'b0;
                            need80_q   <= 1'b0;
                            len_pend_q <= 1'b0;
                        end else if (need80_q) begin
                            need80_q <= 1'b0;
                        end else if (len_pend_q) begin
                            len_pend_q <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready_o  = (state_q == S_FILL);
    assign blk_valid_o = (state_q == S_EMIT);
    assign blk_last_o  = last_blk_q && (state_q == S_EMIT);
    assign busy_o      = (cnt_q != '0) || (state_q != S_FILL);
    assign M_o         = blk_q;

endmodule

// File: tb/tb_md5_msg_padder.sv
// Directed bench for md5_msg_padder: vector table of messages plus
// hand-written backpressure, ignored-input and mid-message reset sequences.
module tb_md5_msg_padder;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic [7:0]        in_data_i = '0;
    logic              in_valid_i = 1'b0;
    logic              in_last_i = 1'b0;
    logic              in_ready_o;
    logic              msg_empty_i = 1'b0;
    logic [15:0][31:0] M_o;
    logic              blk_valid_o;
    logic              blk_last_o;
    logic              blk_ready_i = 1'b1;
    logic              busy_o;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int          cyc = 0;
    int          cyc_accept = 0;
    int          cyc_valid = 0;

    logic [7:0]   msg_q[$];
    logic [511:0] blk_got[4];
    logic         last_got[4];

    typedef struct {
        int unsigned len;
        logic [7:0]  base;
        logic        use_empty;
        int unsigned nblk;
        logic [31:0] w0, w13, w14, w15;   // final block
        logic [31:0] f14, f15;            // first block, multi-block messages only
    } vec_t;

    vec_t tbl[7];

    md5_msg_padder #(.CNT_W(61)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_last_i   (in_last_i),
        .in_ready_o  (in_ready_o),
        .msg_empty_i (msg_empty_i),
        .M_o         (M_o),
        .blk_valid_o (blk_valid_o),
        .blk_last_o  (blk_last_o),
        .blk_ready_i (blk_ready_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check512(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference padding built byte by byte from the message queue.
    function automatic logic [511:0] exp_block(input int unsigned b, input int unsigned len,
                                               input int unsigned nblk);
        logic [511:0] e;
        int unsigned  idx;
        e = '0;
        for (int unsigned j = 0; j < 64; j++) begin
            idx = b * 64 + j;
            if (idx < len)
                e[8*j +: 8] = msg_q[idx];
            else if (idx == len)
                e[8*j +: 8] = 8'h80;
        end
        if (b == nblk - 1)
            e[511:448] = 64'(len) * 64'd8;
        return e;
    endfunction

    task automatic wait_valid(input string tag, output bit ok);
        int guard;
        guard = 0;
        do begin
            @(negedge clk_i);
            guard++;
        end while (!blk_valid_o && guard < 500);
        ok = blk_valid_o;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got blk_valid_o=0 expected 1 within 500 cycles", tag);
        end
    endtask

    task automatic send_msg(input bit use_empty);
        int guard;
        @(negedge clk_i);
        if (use_empty) begin
            msg_empty_i = 1'b1;
            @(negedge clk_i);
            msg_empty_i = 1'b0;
            cyc_accept  = cyc;
        end else begin
            for (int i = 0; i < msg_q.size(); i++) begin
                in_data_i  = msg_q[i];
                in_last_i  = (i == msg_q.size() - 1);
                in_valid_i = 1'b1;
                guard = 0;
                while (!in_ready_o && guard < 500) begin
                    @(negedge clk_i);
                    guard++;
                end
                if (!in_ready_o) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: got in_ready_o=0 expected 1 at byte %0d", i);
                    in_valid_i = 1'b0;
                    in_last_i  = 1'b0;
                    return;
                end
                @(negedge clk_i);
                cyc_accept = cyc;
            end
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic collect(input int unsigned nblk, input string tag);
        bit ok;
        for (int unsigned b = 0; b < nblk; b++) begin
            wait_valid(tag, ok);
            if (!ok) return;
            if (b == 0) cyc_valid = cyc;
            blk_got[b]  = M_o;
            last_got[b] = blk_last_o;
            check512($sformatf("%s_blk%0d", tag, b), M_o, exp_block(b, msg_q.size(), nblk));
            check32($sformatf("%s_last%0d", tag, b), 32'(blk_last_o), 32'(b == nblk - 1));
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        msg_q.delete();
        for (int unsigned i = 0; i < v.len; i++) msg_q.push_back(8'(v.base + i));
        fork
            send_msg(v.use_empty);
            collect(v.nblk, tag);
        join
        check32({tag, "_w0"},  blk_got[v.nblk-1][31:0],    v.w0);
        check32({tag, "_w13"}, blk_got[v.nblk-1][447:416], v.w13);
        check32({tag, "_w14"}, blk_got[v.nblk-1][479:448], v.w14);
        check32({tag, "_w15"}, blk_got[v.nblk-1][511:480], v.w15);
        if (v.nblk > 1) begin
            check32({tag, "_f14"}, blk_got[0][479:448], v.f14);
            check32({tag, "_f15"}, blk_got[0][511:480], v.f15);
        end else begin
            check32({tag, "_latency"}, 32'(cyc_valid - cyc_accept + 1), 32'd3);
        end
        @(negedge clk_i);
        check32({tag, "_busy_after"}, 32'(busy_o), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check32({tag, "_in_ready"},  32'(in_ready_o),  32'd1);
        check32({tag, "_blk_valid"}, 32'(blk_valid_o), 32'd0);
        check32({tag, "_blk_last"},  32'(blk_last_o),  32'd0);
        check32({tag, "_busy"},      32'(busy_o),      32'd0);
        check512({tag, "_M"}, M_o, '0);
    endtask

    initial begin
        logic [511:0] snap;
        bit           ok;

        tbl[0] = '{3,   8'h61, 1'b0, 1, 32'h80636261, 32'h0,        32'h00000018, 32'h0, 32'h0,        32'h0};
        tbl[1] = '{0,   8'h00, 1'b1, 1, 32'h00000080, 32'h0,        32'h00000000, 32'h0, 32'h0,        32'h0};
        tbl[2] = '{1,   8'hAA, 1'b0, 1, 32'h000080AA, 32'h0,        32'h00000008, 32'h0, 32'h0,        32'h0};
        tbl[3] = '{55,  8'h00, 1'b0, 1, 32'h03020100, 32'h80363534, 32'h000001B8, 32'h0, 32'h0,        32'h0};
        tbl[4] = '{56,  8'h00, 1'b0, 2, 32'h00000000, 32'h0,        32'h000001C0, 32'h0, 32'h00000080, 32'h0};
        tbl[5] = '{64,  8'h00, 1'b0, 2, 32'h00000080, 32'h0,        32'h00000200, 32'h0, 32'h3B3A3938, 32'h3F3E3D3C};
        tbl[6] = '{120, 8'h00, 1'b0, 3, 32'h00000000, 32'h0,        32'h000003C0, 32'h0, 32'h3B3A3938, 32'h3F3E3D3C};

        repeat (3) @(negedge clk_i);
        check_idle_outputs("reset");
        rst_i = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // msg_empty_i mid-message and in_last_i without in_valid_i must be ignored.
        msg_q.delete();
        msg_q.push_back(8'h11);
        msg_q.push_back(8'h22);
        fork
            begin
                @(negedge clk_i);
                in_data_i  = 8'h11;
                in_valid_i = 1'b1;
                @(negedge clk_i);
                in_valid_i  = 1'b0;
                msg_empty_i = 1'b1;
                in_last_i   = 1'b1;
                @(negedge clk_i);
                msg_empty_i = 1'b0;
                in_last_i   = 1'b0;
                check32("ignore_in_ready", 32'(in_ready_o), 32'd1);
                check32("ignore_busy", 32'(busy_o), 32'd1);
                in_data_i  = 8'h22;
                in_valid_i = 1'b1;
                in_last_i  = 1'b1;
                @(negedge clk_i);
                cyc_accept = cyc;
                in_valid_i = 1'b0;
                in_last_i  = 1'b0;
            end
            collect(1, "ignore");
        join
        check32("ignore_w0", blk_got[0][31:0], 32'h00802211);
        check32("ignore_w14", blk_got[0][479:448], 32'h00000010);
        check32("ignore_latency", 32'(cyc_valid - cyc_accept + 1), 32'd3);
        @(negedge clk_i);

        // Backpressure: block held for 10 cycles.
        blk_ready_i = 1'b0;
        msg_q.delete();
        msg_q.push_back(8'h61);
        msg_q.push_back(8'h62);
        msg_q.push_back(8'h63);
        fork
            send_msg(1'b0);
            wait_valid("bp", ok);
        join
        snap = M_o;
        check512("bp_block", snap, exp_block(0, 3, 1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check512($sformatf("bp_M_stable%0d", i), M_o, snap);
            check32($sformatf("bp_in_ready%0d", i), 32'(in_ready_o), 32'd0);
            check32($sformatf("bp_valid%0d", i), 32'(blk_valid_o), 32'd1);
            check32($sformatf("bp_last%0d", i), 32'(blk_last_o), 32'd1);
        end
        blk_ready_i = 1'b1;
        @(negedge clk_i);
        check32("bp_release_valid", 32'(blk_valid_o), 32'd0);
        check32("bp_release_in_ready", 32'(in_ready_o), 32'd1);
        check32("bp_release_busy", 32'(busy_o), 32'd0);

        // Second message dropped by reset while its block waits in EMIT.
        blk_ready_i = 1'b0;
        fork
            send_msg(1'b0);
            wait_valid("rst", ok);
        join
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_idle_outputs("midrst");
        @(negedge clk_i);
        rst_i       = 1'b1;
        blk_ready_i = 1'b1;
        @(negedge clk_i);
        check_idle_outputs("postrst");

        // Count must restart from zero after the dropped message.
        run_vec(tbl[0], "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
